// File: rtl/v810_exc_seq_if.sv
// Pipeline / system-register side bundle of the V810 exception sequencer.
interface v810_exc_seq_if;
    // requests from the pipeline
    logic        EXC_REQ;
    logic [15:0] EXC_CODE;
    logic        INT_REQ;
    logic [3:0]  INT_LEVEL;
    logic        RETI_REQ;
    logic [31:0] CUR_PC;
    logic [31:0] PSW;
    // system-register block port
    logic [4:0]  SR_RA;
    logic [31:0] SR_RD;
    logic [4:0]  SR_WA;
    logic [31:0] SR_WD;
    logic        SR_WE;
    logic [31:0] PSW_RESET;
    logic [31:0] PSW_SET;
    logic [15:0] ECR_CC;
    logic        ECR_SET_EICC;
    logic        ECR_SET_FECC;
    // status and fetch redirect
    logic        BUSY;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        FATAL;

    // environment side: pipeline plus system-register block
    modport master (
        output EXC_REQ, EXC_CODE, INT_REQ, INT_LEVEL, RETI_REQ, CUR_PC, PSW, SR_RD,
        input  SR_RA, SR_WA, SR_WD, SR_WE, PSW_RESET, PSW_SET, ECR_CC,
               ECR_SET_EICC, ECR_SET_FECC, BUSY, REDIRECT, REDIRECT_PC, FATAL
    );

    // sequencer side
    modport slave (
        input  EXC_REQ, EXC_CODE, INT_REQ, INT_LEVEL, RETI_REQ, CUR_PC, PSW, SR_RD,
        output SR_RA, SR_WA, SR_WD, SR_WE, PSW_RESET, PSW_SET, ECR_CC,
               ECR_SET_EICC, ECR_SET_FECC, BUSY, REDIRECT, REDIRECT_PC, FATAL
    );
endinterface

// File: rtl/v810_exc_seq.sv
// V810 exception / interrupt / RETI sequencer. Saves PC/PSW into EIPC/EIPSW
// or FEPC/FEPSW, updates PSW and ECR, restores on RETI, then redirects fetch.
module v810_exc_seq (
    input  logic          CLK,
    input  logic          RESn,
    input  logic          CE,
    v810_exc_seq_if.slave bus
);
    localparam logic [4:0] SR_EIPC  = 5'd0;
    localparam logic [4:0] SR_EIPSW = 5'd1;
    localparam logic [4:0] SR_FEPC  = 5'd2;
    localparam logic [4:0] SR_FEPSW = 5'd3;
    localparam logic [4:0] SR_PSW   = 5'd5;

    localparam int B_ID = 12;
    localparam int B_AE = 13;
    localparam int B_EP = 14;
    localparam int B_NP = 15;

    typedef enum logic [2:0] {
        IDLE, SAVE_PC, SAVE_PSW, RET_PC, RET_PSW, REDIR, HALT
    } state_t;

    // everything captured at acceptance; outputs decode only from this
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] psw;
        logic [15:0] code;
        logic [3:0]  lvl;
        logic        is_int;
        logic        dup;
        logic        reti;
    } ctx_t;

    state_t      state, state_nx;
    ctx_t        ctx, ctx_nx;
    logic [31:0] ret_pc;
    logic        int_ok;
    logic [3:0]  lvl_inc;

    // maskable interrupt passes NP/EP/ID and the level threshold
    assign int_ok = bus.INT_REQ && !bus.PSW[B_NP] && !bus.PSW[B_EP] && !bus.PSW[B_ID]
                    && (bus.INT_LEVEL >= bus.PSW[19:16]);

    // new interrupt mask level, saturating at 15
    assign lvl_inc = (ctx.lvl == 4'hF) ? 4'hF : ctx.lvl + 4'd1;

    // request arbitration in IDLE and fixed one-cycle-per-state sequencing
    always_comb begin
        state_nx = state;
        ctx_nx   = ctx;
        case (state)
            IDLE: begin
                if (bus.EXC_REQ) begin
                    ctx_nx.pc     = bus.CUR_PC;
                    ctx_nx.psw    = bus.PSW;
                    ctx_nx.code   = bus.EXC_CODE;
                    ctx_nx.lvl    = 4'd0;
                    ctx_nx.is_int = 1'b0;
                    ctx_nx.dup    = bus.PSW[B_EP];
                    ctx_nx.reti   = 1'b0;
                    state_nx      = bus.PSW[B_NP] ? HALT : SAVE_PC;
                end else if (bus.RETI_REQ) begin
                    ctx_nx.pc     = bus.CUR_PC;
                    ctx_nx.psw    = bus.PSW;
                    ctx_nx.code   = 16'd0;
                    ctx_nx.lvl    = 4'd0;
                    ctx_nx.is_int = 1'b0;
                    ctx_nx.dup    = 1'b0;
                    ctx_nx.reti   = 1'b1;
                    state_nx      = RET_PC;
                end else if (int_ok) begin
                    ctx_nx.pc     = bus.CUR_PC;
                    ctx_nx.psw    = bus.PSW;
                    ctx_nx.code   = {8'hFE, bus.INT_LEVEL, 4'h0};
                    ctx_nx.lvl    = bus.INT_LEVEL;
                    ctx_nx.is_int = 1'b1;
                    ctx_nx.dup    = 1'b0;
                    ctx_nx.reti   = 1'b0;
                    state_nx      = SAVE_PC;
                end
            end
            SAVE_PC:  state_nx = SAVE_PSW;
            SAVE_PSW: state_nx = REDIR;
            RET_PC:   state_nx = RET_PSW;
            RET_PSW:  state_nx = REDIR;
            REDIR:    state_nx = IDLE;
            HALT:     state_nx = HALT;
            default:  state_nx = IDLE;
        endcase
    end

    // state and context advance only on enabled edges
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state <= IDLE;
            ctx   <= '0;
        end else if (CE) begin
            state <= state_nx;
            ctx   <= ctx_nx;
        end
    end

    // return PC from the EIPC/FEPC read, forced halfword aligned
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn)
            ret_pc <= '0;
        else if (CE && state == RET_PC)
            ret_pc <= {bus.SR_RD[31:1], 1'b0};
    end

    // restore read select; kept apart so SR_RD -> SR_WD is not a comb loop
    always_comb begin
        bus.SR_RA = 5'd0;
        if (state == RET_PC)
            bus.SR_RA = ctx.psw[B_NP] ? SR_FEPC : SR_EIPC;
        else if (state == RET_PSW)
            bus.SR_RA = ctx.psw[B_NP] ? SR_FEPSW : SR_EIPSW;
    end

    // write port, PSW masks, ECR strobes and redirect decoded per state
    always_comb begin
        bus.SR_WA        = 5'd0;
        bus.SR_WD        = 32'd0;
        bus.SR_WE        = 1'b0;
        bus.PSW_RESET    = 32'd0;
        bus.PSW_SET      = 32'd0;
        bus.ECR_CC       = 16'd0;
        bus.ECR_SET_EICC = 1'b0;
        bus.ECR_SET_FECC = 1'b0;
        bus.BUSY         = (state != IDLE);
        bus.REDIRECT     = 1'b0;
        bus.REDIRECT_PC  = 32'd0;
        bus.FATAL        = 1'b0;
        case (state)
            SAVE_PC: begin
                bus.SR_WE = 1'b1;
                bus.SR_WA = ctx.dup ? SR_FEPC : SR_EIPC;
                bus.SR_WD = ctx.pc;
            end
            SAVE_PSW: begin
                bus.SR_WE            = 1'b1;
                bus.SR_WA            = ctx.dup ? SR_FEPSW : SR_EIPSW;
                bus.SR_WD            = ctx.psw;
                bus.ECR_CC           = ctx.code;
                bus.ECR_SET_EICC     = !ctx.dup;
                bus.ECR_SET_FECC     = ctx.dup;
                bus.PSW_SET[B_ID]    = 1'b1;
                bus.PSW_SET[B_EP]    = !ctx.dup;
                bus.PSW_SET[B_NP]    = ctx.dup;
                bus.PSW_RESET[B_AE]  = 1'b1;
                if (ctx.is_int) begin
                    bus.PSW_RESET[19:16] = 4'hF;
                    bus.PSW_SET[19:16]   = lvl_inc;
                end
            end
            RET_PSW: begin
                bus.SR_WE = 1'b1;
                bus.SR_WA = SR_PSW;
                bus.SR_WD = bus.SR_RD;
            end
            REDIR: begin
                bus.REDIRECT = 1'b1;
                if (ctx.reti)
                    bus.REDIRECT_PC = ret_pc;
                else if (ctx.dup)
                    bus.REDIRECT_PC = 32'hFFFF_FFD0;
                else
                    bus.REDIRECT_PC = {16'hFFFF, ctx.code};
            end
            HALT: bus.FATAL = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_v810_exc_seq.sv
// Bench for v810_exc_seq: emulates the system-register block (SR file, PSW,
// ECR), drives table and random transactions, compares end state to a model.
module tb_v810_exc_seq;
    logic CLK = 1'b0;
    logic RESn;
    logic CE;

    v810_exc_seq_if bus ();
    v810_exc_seq dut (.CLK(CLK), .RESn(RESn), .CE(CE), .bus(bus));

    always #5 CLK = ~CLK;

    // emulated system registers; PSW lives at index 5
    logic [31:0] sr [0:31];
    logic [31:0] ecr;
    assign bus.SR_RD = sr[bus.SR_RA];
    assign bus.PSW   = sr[5];

    int checks = 0;
    int errors = 0;
    int nwr, necr, nredir, nbusy, nce;
    logic        fatal_seen;
    logic [31:0] redir_pc;

    logic [31:0] exp_sr [0:31];
    logic [31:0] exp_ecr, exp_rpc;
    logic        exp_acc, exp_fatal;
    int          exp_wr, exp_necr;

    typedef struct {
        logic        exc, intr, reti, hold;
        logic [1:0]  cem;
        logic [15:0] code;
        logic [3:0]  lvl;
        logic [31:0] pc, psw, r0, r1, r2, r3;
        logic [31:0] exp_rpc, exp_psw;
        logic        exp_acc;
    } vec_t;
    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic int out_ones();
        return $countones({bus.SR_RA, bus.SR_WA, bus.SR_WD, bus.SR_WE, bus.PSW_RESET,
                           bus.PSW_SET, bus.ECR_CC, bus.ECR_SET_EICC, bus.ECR_SET_FECC,
                           bus.BUSY, bus.REDIRECT, bus.REDIRECT_PC, bus.FATAL});
    endfunction

    // one clock: sample outputs mid-cycle, apply them as the SR block would at the edge
    task automatic cyc();
        logic        we, eicc, fecc, rdr, bsy;
        logic [4:0]  wa;
        logic [31:0] wd, pset, prst, rpc;
        logic [15:0] cc;
        @(negedge CLK);
        we = bus.SR_WE; wa = bus.SR_WA; wd = bus.SR_WD;
        pset = bus.PSW_SET; prst = bus.PSW_RESET; cc = bus.ECR_CC;
        eicc = bus.ECR_SET_EICC; fecc = bus.ECR_SET_FECC;
        rdr = bus.REDIRECT; rpc = bus.REDIRECT_PC; bsy = bus.BUSY;
        if (bus.FATAL) fatal_seen = 1'b1;
        @(posedge CLK);
        #1;
        if (CE && RESn) begin
            nce++;
            if (we) begin sr[wa] = wd; nwr++; end
            sr[5] = (sr[5] & ~prst) | pset;
            if (eicc) begin ecr[15:0]  = cc; necr++; end
            if (fecc) begin ecr[31:16] = cc; necr++; end
            if (rdr) begin nredir++; redir_pc = rpc; end
            if (bsy) nbusy++;
        end
    endtask

    // architectural effect of one request, straight from the V810 rules
    task automatic model(input logic exc, input logic intr, input logic reti,
                         input logic [15:0] code, input logic [3:0] lvl, input logic [31:0] pc);
        logic [31:0] p;
        logic [15:0] c;
        logic [3:0]  nl;
        p = sr[5]; exp_sr = sr; exp_ecr = ecr;
        exp_acc = 0; exp_fatal = 0; exp_rpc = 0; exp_wr = 0; exp_necr = 0;
        if (exc) begin
            if (p[15]) exp_fatal = 1;
            else begin
                exp_acc = 1; exp_wr = 2; exp_necr = 1;
                if (p[14]) begin
                    exp_sr[2] = pc; exp_sr[3] = p; exp_ecr[31:16] = code;
                    exp_sr[5] = (p & ~32'h2000) | 32'h9000;
                    exp_rpc = 32'hFFFF_FFD0;
                end else begin
                    exp_sr[0] = pc; exp_sr[1] = p; exp_ecr[15:0] = code;
                    exp_sr[5] = (p & ~32'h2000) | 32'h5000;
                    exp_rpc = {16'hFFFF, code};
                end
            end
        end else if (reti) begin
            exp_acc = 1; exp_wr = 1;
            exp_rpc = (p[15] ? sr[2] : sr[0]) & ~32'h1;
            exp_sr[5] = p[15] ? sr[3] : sr[1];
        end else if (intr && p[15:14] == 2'b00 && !p[12] && lvl >= p[19:16]) begin
            c  = 16'hFE00 | (16'(lvl) << 4);
            nl = (lvl == 4'hF) ? 4'hF : lvl + 4'd1;
            exp_acc = 1; exp_wr = 2; exp_necr = 1;
            exp_sr[0] = pc; exp_sr[1] = p; exp_ecr[15:0] = c;
            exp_sr[5] = (p & ~32'h000F_2000) | 32'h5000 | (32'(nl) << 16);
            exp_rpc = {16'hFFFF, c};
        end
    endtask

    task automatic compare(input string tag);
        for (int k = 0; k < 8; k++) chk($sformatf("%s sr%0d", tag, k), sr[k], exp_sr[k]);
        chk({tag, " ecr"}, ecr, exp_ecr);
        chk({tag, " fatal"}, 32'(fatal_seen), 32'(exp_fatal));
        chk({tag, " nredir"}, nredir, exp_acc ? 1 : 0);
        if (exp_acc) chk({tag, " redir_pc"}, redir_pc, exp_rpc);
        chk({tag, " sr_writes"}, nwr, exp_wr);
        chk({tag, " ecr_strobes"}, necr, exp_necr);
        if (!exp_fatal) chk({tag, " busy_cycles"}, nbusy, exp_acc ? 3 : 0);
    endtask

    // hold requests until redirect/fatal (bounded), compare, then check it stays idle
    task automatic run_txn(input string tag, input logic exc, input logic intr, input logic reti,
                           input logic hold, input logic [1:0] cem, input logic [15:0] code,
                           input logic [3:0] lvl, input logic [31:0] pc);
        int b0;
        nwr = 0; necr = 0; nredir = 0; nbusy = 0; nce = 0; fatal_seen = 0; redir_pc = 0;
        bus.EXC_REQ = exc; bus.INT_REQ = intr; bus.RETI_REQ = reti;
        bus.EXC_CODE = code; bus.INT_LEVEL = lvl; bus.CUR_PC = pc;
        for (int i = 0; i < 80; i++) begin
            CE = (cem == 2'd0) ? 1'b1 : (cem == 2'd1) ? i[0] : 1'($urandom_range(0, 1));
            cyc();
            if (nredir != 0 || fatal_seen) break;
            if (!exp_acc && !exp_fatal && nce >= 6) break;
        end
        bus.EXC_REQ = 0; bus.RETI_REQ = 0; bus.INT_REQ = hold & intr; CE = 1;
        compare(tag);
        if (!exp_fatal) begin
            b0 = nbusy;
            repeat (4) cyc();
            chk({tag, " idle_after"}, nbusy - b0, 0);
        end
        bus.INT_REQ = 0;
    endtask

    task automatic do_reset();
        RESn = 0; CE = 0;
        cyc(); cyc();
        RESn = 1;
    endtask

    initial begin
        int hold_cnt;
        logic [31:0] ecr_b;
        logic [31:0] p;
        int k;
        logic [1:0] cem;

        vecs[0]  = '{1,0,0,0,0, 16'hFF60, 4'd0,  32'h0700_0010, 32'h0000_0000, 0, 0, 0, 0, 32'hFFFF_FF60, 32'h0000_5000, 1};
        vecs[1]  = '{1,0,0,0,0, 16'hFF90, 4'd0,  32'h0700_0100, 32'h0000_4000, 0, 0, 0, 0, 32'hFFFF_FFD0, 32'h0000_D000, 1};
        vecs[2]  = '{0,1,0,0,0, 16'h0000, 4'd4,  32'h0700_0200, 32'h0005_0000, 0, 0, 0, 0, 32'h0,         32'h0005_0000, 0};
        vecs[3]  = '{0,1,0,0,0, 16'h0000, 4'd7,  32'h0700_0204, 32'h0005_0000, 0, 0, 0, 0, 32'hFFFF_FE70, 32'h0008_5000, 1};
        vecs[4]  = '{0,1,0,0,0, 16'h0000, 4'd15, 32'h0700_0208, 32'h0005_0000, 0, 0, 0, 0, 32'hFFFF_FEF0, 32'h000F_5000, 1};
        vecs[5]  = '{0,0,1,0,0, 16'h0000, 4'd0,  32'h0,         32'h0000_0000, 32'h0700_0020, 32'h0000_1000,
                     32'h0A00_0000, 32'h0000_F000, 32'h0700_0020, 32'h0000_1000, 1};
        vecs[6]  = '{0,0,1,0,0, 16'h0000, 4'd0,  32'h0,         32'h0000_8000, 32'h0700_0020, 32'h0000_1000,
                     32'h0700_0031, 32'h0000_2000, 32'h0700_0030, 32'h0000_2000, 1};
        vecs[7]  = '{1,1,0,1,0, 16'hFF60, 4'd15, 32'h0700_0300, 32'h0000_0000, 0, 0, 0, 0, 32'hFFFF_FF60, 32'h0000_5000, 1};
        vecs[8]  = '{1,0,0,0,0, 16'hFF70, 4'd0,  32'h0700_0400, 32'h0000_2000, 0, 0, 0, 0, 32'hFFFF_FF70, 32'h0000_5000, 1};
        vecs[9]  = '{1,0,0,0,1, 16'hFF60, 4'd0,  32'h0700_0010, 32'h0000_0000, 0, 0, 0, 0, 32'hFFFF_FF60, 32'h0000_5000, 1};
        vecs[10] = '{0,1,0,0,1, 16'h0000, 4'd3,  32'h0700_0500, 32'h0002_0000, 0, 0, 0, 0, 32'hFFFF_FE30, 32'h0004_5000, 1};
        vecs[11] = '{0,1,0,0,0, 16'h0000, 4'd15, 32'h0700_0504, 32'h0000_1000, 0, 0, 0, 0, 32'h0,         32'h0000_1000, 0};

        for (int i = 0; i < 32; i++) sr[i] = 32'd0;
        ecr = 0; fatal_seen = 0; redir_pc = 0;
        nwr = 0; necr = 0; nredir = 0; nbusy = 0; nce = 0;
        bus.EXC_REQ = 0; bus.EXC_CODE = 0; bus.INT_REQ = 0; bus.INT_LEVEL = 0;
        bus.RETI_REQ = 0; bus.CUR_PC = 0;
        RESn = 0; CE = 0;
        #12;
        chk("reset outputs", out_ones(), 0);
        @(posedge CLK); #1;
        RESn = 1;
        cyc();
        chk("idle after reset", 32'(bus.BUSY), 0);

        // directed table
        for (int v = 0; v < NV; v++) begin
            sr[0] = vecs[v].r0; sr[1] = vecs[v].r1; sr[2] = vecs[v].r2; sr[3] = vecs[v].r3;
            sr[5] = vecs[v].psw;
            model(vecs[v].exc, vecs[v].intr, vecs[v].reti, vecs[v].code, vecs[v].lvl, vecs[v].pc);
            run_txn($sformatf("vec%0d", v), vecs[v].exc, vecs[v].intr, vecs[v].reti, vecs[v].hold,
                    vecs[v].cem, vecs[v].code, vecs[v].lvl, vecs[v].pc);
            chk($sformatf("vec%0d table psw", v), sr[5], vecs[v].exp_psw);
            chk($sformatf("vec%0d table taken", v), nredir, vecs[v].exp_acc ? 1 : 0);
            if (vecs[v].exp_acc) chk($sformatf("vec%0d table redir_pc", v), redir_pc, vecs[v].exp_rpc);
        end

        // fatal: NP=1 exception halts, FATAL holds, reset clears it
        sr[5] = 32'h0000_8000;
        model(1, 0, 0, 16'hFF40, 4'd0, 32'h0700_0600);
        run_txn("fatal", 1, 0, 0, 0, 2'd0, 16'hFF40, 4'd0, 32'h0700_0600);
        hold_cnt = 0; nwr = 0; necr = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus.FATAL === 1'b1) hold_cnt++;
        end
        chk("fatal hold", hold_cnt, 20);
        chk("fatal no writes", nwr + necr, 0);
        RESn = 0;
        #1;
        chk("fatal reset outputs", out_ones(), 0);
        cyc();
        RESn = 1;
        cyc();

        // reset pulse while in SAVE_PSW abandons the sequence
        sr[5] = 0; ecr_b = ecr; CE = 1;
        bus.EXC_REQ = 1; bus.EXC_CODE = 16'hFF50; bus.CUR_PC = 32'h0700_0700;
        cyc(); cyc();
        chk("mid in save_psw", 32'(bus.ECR_SET_EICC), 1);
        RESn = 0;
        #1;
        chk("mid reset outputs", out_ones(), 0);
        bus.EXC_REQ = 0;
        cyc(); cyc();
        RESn = 1; nbusy = 0;
        repeat (4) cyc();
        chk("mid idle", nbusy, 0);
        chk("mid ecr untouched", ecr, ecr_b);
        chk("mid psw untouched", sr[5], 0);

        // randomized transactions against the model
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < 4; i++) sr[i] = $urandom;
            p = $urandom;
            p[15] = ($urandom_range(0, 7) == 0);
            p[14] = ($urandom_range(0, 3) == 0);
            p[12] = ($urandom_range(0, 3) == 0);
            sr[5] = p;
            k = $urandom_range(0, 9);
            cem = 2'($urandom_range(0, 2));
            bus.EXC_CODE = 16'($urandom);
            bus.INT_LEVEL = 4'($urandom);
            bus.CUR_PC = $urandom;
            model(k <= 3 || k == 9, k >= 6, k == 4 || k == 5, bus.EXC_CODE, bus.INT_LEVEL, bus.CUR_PC);
            run_txn($sformatf("rnd%0d", t), k <= 3 || k == 9, k >= 6, k == 4 || k == 5, 1'b0, cem,
                    bus.EXC_CODE, bus.INT_LEVEL, bus.CUR_PC);
            if (exp_fatal) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
